// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit and sequencer for the EX stage of the
// 5-stage MIPS pipeline. Owns the architectural HI/LO registers.
//
// Ports:
//   clk        core clock, rising-edge state updates
//   reset      asynchronous active-low reset
//   start      EX-stage MD-class instruction valid this cycle
//   md_op      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_data    forwarded rs operand
//   rt_data    forwarded rt operand
//   req        exception/interrupt flush of the EX instruction
//   id_md_use  ID-stage instruction uses the MD unit or reads HI/LO
//   rd_sel     MFHI/MFLO select: 0 = LO, 1 = HI
//   busy       multi-cycle operation in progress
//   stall      freeze front end, bubble into EX
//   hi, lo     committed HI/LO registers
//   rd_data    combinational HI/LO read mux
//
// The 64-bit result is computed in the start cycle and parked in pending
// registers; the latency counter only models the architectural busy time.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  input  logic        id_md_use,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      pend_hi_reg, pend_hi_next;
  logic [31:0]      pend_lo_reg, pend_lo_next;
  logic             pend_we_reg, pend_we_next;

  logic             eff_start;
  logic             is_md_long;

  // ---------------- arithmetic ----------------
  logic signed [63:0] smul;
  logic [63:0]        umul;

  assign smul = $signed(rs_data) * $signed(rt_data);
  assign umul = {32'b0, rs_data} * {32'b0, rt_data};

  // One unsigned divider serves both DIV and DIVU. For DIV the operands are
  // reduced to magnitudes and the signs re-applied afterwards; this also makes
  // 0x80000000 / -1 wrap naturally to 0x80000000 with remainder 0.
  logic        div_signed;
  logic        num_neg, den_neg;
  logic [31:0] num_mag, den_mag, den_safe;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quot, rem;
  logic        div_by_zero;

  assign div_signed  = (md_op == OP_DIV);
  assign num_neg     = div_signed & rs_data[31];
  assign den_neg     = div_signed & rt_data[31];
  assign num_mag     = num_neg ? (32'd0 - rs_data) : rs_data;
  assign den_mag     = den_neg ? (32'd0 - rt_data) : rt_data;
  assign div_by_zero = (rt_data == 32'd0);
  // Keep the divider well-defined on zero; the result is discarded anyway.
  assign den_safe    = div_by_zero ? 32'd1 : den_mag;
  assign q_mag       = num_mag / den_safe;
  assign r_mag       = num_mag % den_safe;
  assign quot        = (num_neg ^ den_neg) ? (32'd0 - q_mag) : q_mag;
  // Remainder follows the sign of the dividend.
  assign rem         = num_neg ? (32'd0 - r_mag) : r_mag;

  // ---------------- control ----------------
  assign is_md_long = (md_op == OP_MULT) | (md_op == OP_MULTU) |
                      (md_op == OP_DIV)  | (md_op == OP_DIVU);
  assign eff_start  = start & ~req & (state_reg == ST_IDLE);

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_we_next = pend_we_reg;

    case (state_reg)
      ST_IDLE: begin
        if (eff_start) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_next, pend_lo_next} = smul;
              pend_we_next = 1'b1;
              count_next   = MULT_CNT;
              state_next   = ST_BUSY;
            end
            OP_MULTU: begin
              {pend_hi_next, pend_lo_next} = umul;
              pend_we_next = 1'b1;
              count_next   = MULT_CNT;
              state_next   = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_next = rem;
              pend_lo_next = quot;
              // Divide by zero still costs the full latency but commits nothing.
              pend_we_next = ~div_by_zero;
              count_next   = DIV_CNT;
              state_next   = ST_BUSY;
            end
            OP_MTHI: hi_next = rs_data;
            OP_MTLO: lo_next = rs_data;
            default: ;
          endcase
        end
      end
      default: begin
        count_next = count_reg - CNT_ONE;
        if (count_reg == CNT_ONE) begin
          if (pend_we_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_we_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_we_reg <= pend_we_next;
    end
  end

  assign busy    = (state_reg == ST_BUSY);
  // The start term catches an MD instruction in ID while a long op is being
  // launched from EX this very cycle (busy has not risen yet).
  assign stall   = id_md_use & (busy | (start & ~req & is_md_long));
  assign hi      = hi_reg;
  assign lo      = lo_reg;
  assign rd_data = rd_sel ? hi_reg : lo_reg;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit and its sequencer for the 5-stage pipelined MIPS core. Sits in the EX stage next to the ALU and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX-stage decode and runs multi-cycle operations under a latency counter.
- Generates the ID-stage stall for any MD-class instruction that arrives while the unit is busy.
- Suppresses starts for instructions that are being flushed by an exception or interrupt request.

Parameters:
- MULT_LAT, 5, cycles busy is held for MULT/MULTU (must be ≥1).
- DIV_LAT, 10, cycles busy is held for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is MD-class and valid this cycle.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- req  input  1  exception/interrupt flush of the EX instruction this cycle.
- id_md_use  input  1  ID-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- rd_sel  input  1  MFHI/MFLO read select: 0 = LO, 1 = HI.
- busy  output  1  multi-cycle operation in progress.
- stall  output  1  freeze PC, IF/ID and ID/EX; bubble into EX.
- hi  output  32  HI register.
- lo  output  32  LO register.
- rd_data  output  32  combinational: hi if rd_sel = 1, else lo.

Behaviour:
- Reset (async, reset = 0):
  - State = IDLE, counter = 0, busy = 0, hi = 0, lo = 0, pending result regs = 0.
  - Reset asserted mid-operation aborts it; HI/LO return to 0, no write-back.
- States:
  - IDLE: counter = 0.
  - BUSY: counter ≠ 0.
- Accept condition: eff_start = start & ~req & (state == IDLE).
  - start while BUSY is ignored; the stall prevents it in legal operation.
  - start with req = 1 is discarded entirely: no state change, no HI/LO write.
- IDLE, eff_start, md_op 0–3:
  - Compute the 64-bit result from rs_data/rt_data and store it in pending regs.
  - Load counter with MULT_LAT (op 0/1) or DIV_LAT (op 2/3); go to BUSY.
  - busy rises the cycle after the start edge.
- BUSY: counter decrements each cycle.
  - On the edge where counter goes 1→0, pending HI/LO are written to hi/lo; state returns to IDLE.
  - busy is high for exactly LAT cycles.
  - HI/LO hold their old values throughout BUSY.
- IDLE, eff_start, md_op 4/5: single cycle, no busy.
  - MTHI: hi <= rs_data.
  - MTLO: lo <= rs_data.
- md_op 6/7: no effect.
- Arithmetic:
  - MULT: signed 32x32→64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32x32→64; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (rt_data = 0): the operation still occupies DIV_LAT busy cycles, and hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Stall (combinational):
  - stall = id_md_use & (busy | (start & ~req & md_op ∈ {0..3})).
  - Covers an MD instruction in ID while one is starting in EX.
  - Covers MFHI/MFLO reading stale HI/LO.
- rd_data always reflects the committed hi/lo, never pending results.

Test Plan:
- MULT rs = 0xFFFFFFFF, rt = 2 → busy high 5 cycles → hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; MULTU with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2 → busy 10 cycles → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100/7 → lo = 14, hi = 2.
- Prior hi = 0x11, lo = 0x22; DIV by zero → busy 10 cycles, hi/lo unchanged; DIV 0x80000000 / -1 → lo = 0x80000000, hi = 0.
- MULT started with id_md_use = 1 (MFLO in ID) → stall high on the start cycle and all 5 busy cycles, low the cycle after completion; rd_sel = 0 then returns the new lo. With id_md_use = 0, stall stays 0 throughout.
- start = 1 with req = 1, md_op = DIV → busy stays 0, hi/lo unchanged, stall = 0; MTHI rs = 0xABCD0000 → hi updates next edge, busy never rises.
- MULT started, reset pulled low at busy cycle 3 → busy = 0 and hi = lo = 0 immediately (asynchronously); after release, no late write-back occurs.
